// File: rtl/mult_pipe_pkg.sv
// Shared constants and types for the multiply execution pipeline.
package mult_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 8;

  typedef struct packed {
    logic zero;
    logic overflow;
  } mult_flags_t;

endpackage

// File: rtl/mult_stage_reg.sv
// One pipeline slice: valid, writeback control and a generic payload.
module mult_stage_reg #(
  parameter int ADDR_W = 5,
  parameter int PAY_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_d,
  input  logic              regwrite_d,
  input  logic [ADDR_W-1:0] wreg_d,
  input  logic [PAY_W-1:0]  payload_d,
  output logic              valid_q,
  output logic              regwrite_q,
  output logic [ADDR_W-1:0] wreg_q,
  output logic [PAY_W-1:0]  payload_q
);

  // Flush only kills the control bits; stale payload is harmless once valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      payload_q  <= '0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      payload_q  <= payload_d;
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// Configurable-depth multiply pipeline with zero/overflow flags and hazard taps.
module mult_pipe
  import mult_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STAGES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic                     signed_in,
  input  logic [DATA_W-1:0]        opa,
  input  logic [DATA_W-1:0]        opb,
  input  logic                     regwrite_in,
  input  logic [ADDR_W-1:0]        wreg_in,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     ready,
  output logic                     valid_out,
  output logic                     regwrite_out,
  output logic [ADDR_W-1:0]        wreg_out,
  output logic [DATA_W-1:0]        result,
  output logic                     zero,
  output logic                     overflow,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*ADDR_W-1:0] stage_wreg,
  output logic                     busy
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int MID_W  = PROD_W + 1;
  localparam int OUT_W  = DATA_W + $bits(mult_flags_t);

  if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
    $fatal(1, "mult_pipe: STAGES=%0d outside legal range", STAGES);
  end

  logic [PROD_W-1:0] ext_a, ext_b, product;
  logic [STAGES-1:0] valid_q, regwrite_q;
  logic [ADDR_W-1:0] wreg_q [STAGES];
  logic [MID_W-1:0]  mid_q [STAGES-1];
  logic [OUT_W-1:0]  out_d, out_q;
  logic              last_sgn;
  logic [PROD_W-1:0] last_prod;
  mult_flags_t       flags_d, flags_q;

  // Extending both operands to 2*DATA_W makes one unsigned multiplier serve both modes.
  always_comb begin
    ext_a   = signed_in ? {{DATA_W{opa[DATA_W-1]}}, opa} : {{DATA_W{1'b0}}, opa};
    ext_b   = signed_in ? {{DATA_W{opb[DATA_W-1]}}, opb} : {{DATA_W{1'b0}}, opb};
    product = ext_a * ext_b;
  end

  for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_mid
    logic              v_d, rw_d;
    logic [ADDR_W-1:0] w_d;
    logic [MID_W-1:0]  p_d;
    if (gi == 0) begin : g_first
      assign {v_d, rw_d, w_d, p_d} = {valid_in, regwrite_in, wreg_in, signed_in, product};
    end else begin : g_next
      assign {v_d, rw_d, w_d, p_d} = {valid_q[gi-1], regwrite_q[gi-1], wreg_q[gi-1], mid_q[gi-1]};
    end
    mult_stage_reg #(.ADDR_W(ADDR_W), .PAY_W(MID_W)) u_slice (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .valid_d(v_d), .regwrite_d(rw_d), .wreg_d(w_d), .payload_d(p_d),
      .valid_q(valid_q[gi]), .regwrite_q(regwrite_q[gi]),
      .wreg_q(wreg_q[gi]), .payload_q(mid_q[gi])
    );
  end

  // The signed flag rides with the product so overflow can be judged just before the output register.
  always_comb begin
    last_sgn         = mid_q[STAGES-2][PROD_W];
    last_prod        = mid_q[STAGES-2][PROD_W-1:0];
    flags_d.zero     = (last_prod[DATA_W-1:0] == '0);
    flags_d.overflow = last_sgn ? (last_prod[PROD_W-1:DATA_W] != {DATA_W{last_prod[DATA_W-1]}})
                                : (|last_prod[PROD_W-1:DATA_W]);
    out_d            = {flags_d, last_prod[DATA_W-1:0]};
  end

  mult_stage_reg #(.ADDR_W(ADDR_W), .PAY_W(OUT_W)) u_out (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_d(valid_q[STAGES-2]), .regwrite_d(regwrite_q[STAGES-2]),
    .wreg_d(wreg_q[STAGES-2]), .payload_d(out_d),
    .valid_q(valid_q[STAGES-1]), .regwrite_q(regwrite_q[STAGES-1]),
    .wreg_q(wreg_q[STAGES-1]), .payload_q(out_q)
  );

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_taps
    assign stage_wreg[gi*ADDR_W +: ADDR_W] = wreg_q[gi];
  end

  assign flags_q      = out_q[OUT_W-1:DATA_W];
  assign ready        = ~stall;
  assign valid_out    = valid_q[STAGES-1];
  assign regwrite_out = regwrite_q[STAGES-1] & valid_out;
  assign wreg_out     = wreg_q[STAGES-1];
  assign result       = out_q[DATA_W-1:0];
  assign zero         = flags_q.zero & valid_out;
  assign overflow     = flags_q.overflow & valid_out;
  assign stage_valid  = valid_q;
  assign busy         = |valid_q;

endmodule

// File: tb/tb_mult_pipe.sv
// Directed self-checking bench for mult_pipe at the default 32-bit, 4-stage configuration.
module tb_mult_pipe;

  logic        clk = 1'b0;
  logic        rst, valid_in, signed_in, regwrite_in, stall, flush;
  logic [31:0] opa, opb;
  logic [4:0]  wreg_in;
  logic        ready, valid_out, regwrite_out, zero, overflow, busy;
  logic [4:0]  wreg_out;
  logic [31:0] result;
  logic [3:0]  stage_valid;
  logic [19:0] stage_wreg;

  int checks = 0;
  int fails  = 0;

  mult_pipe #(.DATA_W(32), .ADDR_W(5), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .signed_in(signed_in),
    .opa(opa), .opb(opb), .regwrite_in(regwrite_in), .wreg_in(wreg_in),
    .stall(stall), .flush(flush), .ready(ready), .valid_out(valid_out),
    .regwrite_out(regwrite_out), .wreg_out(wreg_out), .result(result),
    .zero(zero), .overflow(overflow), .stage_valid(stage_valid),
    .stage_wreg(stage_wreg), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic set_op(input logic v, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic rw, input logic [4:0] w);
    valid_in = v; signed_in = s; opa = a; opb = b; regwrite_in = rw; wreg_in = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [40:0] obs;
    tick(); tick();
    obs = {valid_out, regwrite_out, wreg_out, result, zero, overflow, stage_valid, busy} >> 0;
    checks++;
    if ({valid_out, regwrite_out, wreg_out, result, zero, overflow, stage_valid, stage_wreg, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got vo=%b rw=%b wr=%0d res=%h z=%b o=%b sv=%b sw=%h busy=%b, need all 0",
               valid_out, regwrite_out, wreg_out, result, zero, overflow, stage_valid, stage_wreg, busy);
    end
    checks++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b need 1", ready);
    end
    $display("reset held: outputs vo=%b busy=%b ready=%b (obs %h)", valid_out, busy, ready, obs);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, 1'b0, 32'(i + 2), 32'd3, 1'b1, 5'(i + 1));
      tick();
    end
    set_op(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0);
    checks++;
    if (stage_valid !== 4'b0111) begin
      fails++;
      $display("FAIL midrst_inflight: stage_valid got %b need 0111", stage_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({valid_out, regwrite_out, wreg_out, result, zero, overflow, stage_valid, stage_wreg, busy} !== '0) begin
      fails++;
      $display("FAIL midrst_async: got vo=%b sv=%b sw=%h busy=%b res=%h, need all 0",
               valid_out, stage_valid, stage_wreg, busy, result);
    end
    $display("reset mid-stream asserted: sv=%b busy=%b", stage_valid, busy);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (valid_out !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL midrst_drain%0d: vo=%b busy=%b need 0 0", i, valid_out, busy);
      end
    end
  endtask

  task automatic test_unsigned();
    set_op(1'b1, 1'b0, 32'd7, 32'd6, 1'b1, 5'd5);
    tick();
    set_op(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0);
    checks++;
    if (stage_valid !== 4'b0001 || stage_wreg[4:0] !== 5'd5) begin
      fails++;
      $display("FAIL unsigned_stage1: sv=%b sw0=%0d need 0001 5", stage_valid, stage_wreg[4:0]);
    end
    tick(); tick();
    checks++;
    if (valid_out !== 1'b0) begin
      fails++;
      $display("FAIL unsigned_early: valid_out got %b need 0 one cycle before latency", valid_out);
    end
    tick();
    checks++;
    if ({valid_out, regwrite_out, wreg_out, result, zero, overflow} !== {1'b1, 1'b1, 5'd5, 32'd42, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL unsigned_7x6: got vo=%b rw=%b wr=%0d res=%0d z=%b o=%b need 1 1 5 42 0 0",
               valid_out, regwrite_out, wreg_out, result, zero, overflow);
    end
    $display("op 7*6 unsigned -> res=%0d wr=%0d z=%b o=%b", result, wreg_out, zero, overflow);
    tick();
    checks++;
    if ({valid_out, regwrite_out, zero, overflow, busy} !== 5'b0) begin
      fails++;
      $display("FAIL unsigned_after: vo=%b rw=%b z=%b o=%b busy=%b need all 0",
               valid_out, regwrite_out, zero, overflow, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic        s_v  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] a_v  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h0,
                              32'h00010000, 32'hFFFFFFFD, 32'h40000000, 32'h40000000};
    logic [31:0] b_v  [8] = '{32'h2, 32'h2, 32'h80000000, 32'h1234,
                              32'h00010000, 32'h5, 32'h2, 32'h2};
    logic        rw_v [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] r_v  [8] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0, 32'h0,
                              32'h0, 32'hFFFFFFF1, 32'h80000000, 32'h80000000};
    logic        z_v  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        o_v  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [40:0] exp_v;
    int          k;
    for (int t = 0; t < 11; t++) begin
      if (t < 8) set_op(1'b1, s_v[t], a_v[t], b_v[t], rw_v[t], 5'(t + 8));
      else       set_op(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0);
      tick();
      if (t >= 3) begin
        k = t - 3;
        exp_v = {1'b1, rw_v[k], 5'(k + 8), r_v[k], z_v[k], o_v[k]};
        checks++;
        if ({valid_out, regwrite_out, wreg_out, result, zero, overflow} !== exp_v) begin
          fails++;
          $display("FAIL b2b_op%0d: got vo=%b rw=%b wr=%0d res=%h z=%b o=%b need vo=1 rw=%b wr=%0d res=%h z=%b o=%b",
                   k, valid_out, regwrite_out, wreg_out, result, zero, overflow,
                   rw_v[k], k + 8, r_v[k], z_v[k], o_v[k]);
        end
        $display("op%0d %s %h*%h -> res=%h z=%b o=%b", k, s_v[k] ? "signed" : "unsigned",
                 a_v[k], b_v[k], result, zero, overflow);
      end
    end
  endtask

  task automatic test_stall();
    logic        st   [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int          in_op[11] = '{0, 1, 2, 2, 2, 3, -1, -1, -1, -1, -1};
    int          out_op[11] = '{-1, -1, -1, -1, -1, 0, 0, 1, 2, 3, -1};
    logic [3:0]  sv_e [11] = '{4'b0001, 4'b0011, 4'b0011, 4'b0011, 4'b0111, 4'b1111,
                               4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [31:0] a_v  [4]  = '{32'd3, 32'd5, 32'd6, 32'd9};
    logic [31:0] b_v  [4]  = '{32'd4, 32'd5, 32'd7, 32'd9};
    logic [31:0] r_v  [4]  = '{32'd12, 32'd25, 32'd42, 32'd81};
    logic [40:0] exp_v;
    for (int c = 0; c < 11; c++) begin
      stall = st[c];
      if (in_op[c] >= 0) set_op(1'b1, 1'b0, a_v[in_op[c]], b_v[in_op[c]], 1'b1, 5'(in_op[c] + 1));
      else               set_op(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0);
      #1;
      checks++;
      if (ready !== ~st[c]) begin
        fails++;
        $display("FAIL stall_ready_c%0d: got %b need %b", c, ready, ~st[c]);
      end
      tick();
      checks++;
      if (stage_valid !== sv_e[c]) begin
        fails++;
        $display("FAIL stall_sv_c%0d: got %b need %b", c, stage_valid, sv_e[c]);
      end
      if (out_op[c] >= 0) exp_v = {1'b1, 1'b1, 5'(out_op[c] + 1), r_v[out_op[c]], 1'b0, 1'b0};
      else                exp_v = {1'b0, 1'b0, wreg_out, result, 1'b0, 1'b0};
      checks++;
      if ({valid_out, regwrite_out, wreg_out, result, zero, overflow} !== exp_v) begin
        fails++;
        $display("FAIL stall_out_c%0d: got vo=%b rw=%b wr=%0d res=%0d need vo=%b wr=%0d res=%0d",
                 c, valid_out, regwrite_out, wreg_out, result, exp_v[40], exp_v[38:34], exp_v[33:2]);
      end
      $display("stall cycle %0d: stall=%b sv=%b vo=%b res=%0d", c, st[c], stage_valid, valid_out, result);
    end
    stall = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, 1'b0, 32'(i + 1), 32'd10, 1'b1, 5'(i + 20));
      tick();
    end
    checks++;
    if (stage_valid !== 4'b0111 || valid_out !== 1'b0) begin
      fails++;
      $display("FAIL flush_pre: sv=%b vo=%b need 0111 0", stage_valid, valid_out);
    end
    set_op(1'b1, 1'b0, 32'd4, 32'd10, 1'b1, 5'd23);
    flush = 1'b1;
    stall = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    set_op(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0);
    checks++;
    if (stage_valid !== 4'b0000 || busy !== 1'b0 || valid_out !== 1'b0) begin
      fails++;
      $display("FAIL flush_clear: sv=%b busy=%b vo=%b need 0000 0 0", stage_valid, busy, valid_out);
    end
    $display("flush+stall: sv=%b busy=%b", stage_valid, busy);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (valid_out !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL flush_drain%0d: vo=%b busy=%b need 0 0", i, valid_out, busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_op(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0);
    test_reset();
    test_reset_midstream();
    test_unsigned();
    test_back_to_back();
    test_stall();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
